// File: rtl/reg_access_master.sv
// reg_access_master
//   Initiator-side sequencer for a bank of NUM_REGS single-port registers.
//   It takes one command at a time on the cmd_* channel, then pulses the
//   one-hot write and/or read enable of the addressed register for one cycle
//   each. The result comes back on the rsp_* channel.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   cmd_valid/ready   command handshake
//   cmd_op            00 WRITE, 01 READ, 10 WRITE_READ, 11 reserved (error)
//   cmd_addr          register index
//   cmd_wdata         write data
//   rsp_valid/ready   response handshake
//   rsp_rdata         read data (0 for writes and errors)
//   rsp_error         address out of range or reserved op
//   reg_write_enable  one-hot write enable to the bank
//   reg_read_enable   one-hot read enable to the bank
//   reg_write_data    data shared by every register write port
//   reg_read_data     concatenated read ports, slice i = register i
//
// state | meaning
// IDLE  | ready for a command
// WR    | write enable of captured address high for one cycle
// RD    | read enable high; addressed slice captured into rsp_rdata
// RESP  | response presented until rsp_ready
module reg_access_master #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  input  logic [ADDR_WIDTH-1:0]          cmd_addr,
  input  logic [DATA_WIDTH-1:0]          cmd_wdata,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_error,
  output logic [NUM_REGS-1:0]            reg_write_enable,
  output logic [NUM_REGS-1:0]            reg_read_enable,
  output logic [DATA_WIDTH-1:0]          reg_write_data,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_read_data
);

  localparam logic [1:0] OP_WRITE      = 2'b00;
  localparam logic [1:0] OP_READ       = 2'b01;
  localparam logic [1:0] OP_WRITE_READ = 2'b10;
  localparam logic [1:0] OP_RSVD       = 2'b11;

  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_then_rd_q, wr_then_rd_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  error_q, error_d;
  logic                  cmd_bad;
  logic [DATA_WIDTH-1:0] rd_slice;

  // Widened compare so NUM_REGS == 2**ADDR_WIDTH does not overflow.
  assign cmd_bad = ({1'b0, cmd_addr} >= (ADDR_WIDTH+1)'(NUM_REGS)) || (cmd_op == OP_RSVD);

  always_comb begin
    rd_slice = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == ADDR_WIDTH'(i)) rd_slice = reg_read_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_then_rd_d = wr_then_rd_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    error_d      = error_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d       = cmd_addr;
          wr_then_rd_d = (cmd_op == OP_WRITE_READ);
          if (cmd_bad) begin
            error_d = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else if (cmd_op == OP_READ) begin
            state_d = RD;
          end else begin
            // OP_WRITE or OP_WRITE_READ: data is launched ahead of the WR cycle.
            wdata_d = cmd_wdata;
            state_d = WR;
          end
        end
      end
      WR: state_d = wr_then_rd_q ? RD : RESP;
      RD: begin
        rdata_d = rd_slice;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rdata_d = '0;
          error_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wr_then_rd_q <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wr_then_rd_q <= wr_then_rd_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      error_q      <= error_d;
    end
  end

  // Enables decode only registered state, so they drop as soon as reset hits.
  always_comb begin
    reg_write_enable = '0;
    reg_read_enable  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_write_enable[i] = (state_q == WR) && (addr_q == ADDR_WIDTH'(i));
      reg_read_enable[i]  = (state_q == RD) && (addr_q == ADDR_WIDTH'(i));
    end
  end

  assign cmd_ready      = (state_q == IDLE) && reset;
  assign rsp_valid      = (state_q == RESP);
  assign rsp_rdata      = rdata_q;
  assign rsp_error      = error_q;
  assign reg_write_data = wdata_q;

  // OP_WRITE is the fall-through case of the IDLE decode.
  logic unused_op;
  assign unused_op = (OP_WRITE == 2'b00);

endmodule

// File: tb/tb_reg_access_master.sv
module tb_reg_access_master;
  localparam int DW = 32;
  localparam int NR = 3;
  localparam int AW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           cmd_valid, cmd_ready;
  logic [1:0]     cmd_op;
  logic [AW-1:0]  cmd_addr;
  logic [DW-1:0]  cmd_wdata;
  logic           rsp_valid, rsp_ready, rsp_error;
  logic [DW-1:0]  rsp_rdata;
  logic [NR-1:0]  we, re;
  logic [DW-1:0]  reg_write_data;
  logic [NR*DW-1:0] reg_read_data;

  logic [DW-1:0] bank [NR];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_access_master #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .reg_write_enable(we), .reg_read_enable(re),
    .reg_write_data(reg_write_data), .reg_read_data(reg_read_data)
  );

  // Register bank: write at the edge that samples the enable, gated read port.
  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) if (we[i]) bank[i] <= reg_write_data;
  end
  always_comb begin
    reg_read_data = '0;
    for (int i = 0; i < NR; i++) reg_read_data[i*DW +: DW] = re[i] ? bank[i] : '0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Issue a command and follow it up to rsp_valid; lat is the number of
  // cycles after the accepting edge spent before rsp_valid rose.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int exp_lat,
                         input logic [NR-1:0] exp_we, input logic [NR-1:0] exp_re,
                         input logic [DW-1:0] exp_rdata, input logic exp_err);
    int lat = -1;
    int we_n = 0, re_n = 0;
    logic [NR-1:0] we_m = '0, re_m = '0;
    logic [DW-1:0] wd_seen = '0;
    issue(op, addr, wd);
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid) begin lat = c; break; end
      chk({tag, "_onehot"}, 32'($countones({we, re}) <= 1), 32'd1);
      if (|we) begin we_m |= we; we_n++; wd_seen = reg_write_data; end
      if (|re) begin re_m |= re; re_n++; end
      @(posedge clk); #1;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_we_mask"}, 32'(we_m), 32'(exp_we));
    chk({tag, "_re_mask"}, 32'(re_m), 32'(exp_re));
    chk({tag, "_we_cycles"}, 32'(we_n), (exp_we != 0) ? 32'd1 : 32'd0);
    chk({tag, "_re_cycles"}, 32'(re_n), (exp_re != 0) ? 32'd1 : 32'd0);
    if (exp_we != 0) chk({tag, "_wdata"}, wd_seen, wd);
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_error"}, 32'(rsp_error), 32'(exp_err));
    chk({tag, "_busy"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_en_resp"}, 32'({we, re}), 32'd0);
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_valid_clr"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rdata_clr"}, rsp_rdata, 32'd0);
    chk({tag, "_error_clr"}, 32'(rsp_error), 32'd0);
    chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0;
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_enables", 32'({we, re}), 32'd0);
    chk("rst_wdata", reg_write_data, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    run_cmd("wr0", 2'b00, 2'd0, 32'h11, 1, 3'b001, 3'b000, 32'h0, 1'b0);
    finish_rsp("wr0");
    run_cmd("wr2", 2'b00, 2'd2, 32'hA5, 1, 3'b100, 3'b000, 32'h0, 1'b0);
    finish_rsp("wr2");
    run_cmd("rd2", 2'b01, 2'd2, 32'h0, 1, 3'b000, 3'b100, 32'hA5, 1'b0);
    finish_rsp("rd2");
    run_cmd("rd0", 2'b01, 2'd0, 32'h0, 1, 3'b000, 3'b001, 32'h11, 1'b0);
    finish_rsp("rd0");
    run_cmd("wrrd1", 2'b10, 2'd1, 32'h3C, 2, 3'b010, 3'b010, 32'h3C, 1'b0);
    finish_rsp("wrrd1");
    run_cmd("oob3", 2'b01, 2'd3, 32'h0, 0, 3'b000, 3'b000, 32'h0, 1'b1);
    finish_rsp("oob3");
    run_cmd("rsvd", 2'b11, 2'd0, 32'hFF, 0, 3'b000, 3'b000, 32'h0, 1'b1);
    finish_rsp("rsvd");
    chk("bank0_kept", bank[0], 32'h11);
    chk("bank2_kept", bank[2], 32'hA5);

    // Response held off for 5 cycles with a new command already waiting.
    run_cmd("wr1", 2'b00, 2'd1, 32'h5A, 1, 3'b010, 3'b000, 32'h0, 1'b0);
    finish_rsp("wr1");
    run_cmd("rd1", 2'b01, 2'd1, 32'h0, 1, 3'b000, 3'b010, 32'h5A, 1'b0);
    cmd_op = 2'b01; cmd_addr = 2'd0; cmd_wdata = '0; cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, 32'h5A);
      chk("hold_ready", 32'(cmd_ready), 32'd0);
      chk("hold_no_en", 32'({we, re}), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("hs_valid_clr", 32'(rsp_valid), 32'd0);
    chk("hs_rdata_clr", rsp_rdata, 32'd0);
    chk("hs_ready", 32'(cmd_ready), 32'd1);
    chk("hs_not_taken", 32'(re), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("next_taken_re", 32'(re), 32'b001);
    chk("next_busy", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("next_valid", 32'(rsp_valid), 32'd1);
    chk("next_rdata", rsp_rdata, 32'h11);
    finish_rsp("next");

    // Reset asserted during the RD cycle of a READ.
    issue(2'b01, 2'd2, 32'h0);
    chk("mid_re_before", 32'(re), 32'b100);
    reset = 1'b0;
    #1;
    chk("mid_re_drop", 32'(re), 32'd0);
    chk("mid_we_drop", 32'(we), 32'd0);
    chk("mid_valid_drop", 32'(rsp_valid), 32'd0);
    chk("mid_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_ready_back", 32'(cmd_ready), 32'd1);
    chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
    run_cmd("wrdb", 2'b00, 2'd1, 32'hDEADBEEF, 1, 3'b010, 3'b000, 32'h0, 1'b0);
    finish_rsp("wrdb");
    run_cmd("rddb", 2'b01, 2'd1, 32'h0, 1, 3'b000, 3'b010, 32'hDEADBEEF, 1'b0);
    finish_rsp("rddb");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
